sram_point_arbiter: RTL and testbench

- Single-port controller for the board SRAM. It shares the SRAM between a point writer (the UART point decoder) and a point reader (the 3D render fetch path).
- Each point is 48 bits, stored as 3 consecutive 16-bit words. Point i occupies word addresses 3i, 3i+1, 3i+2.
- The block owns all SRAM pins, the write pointer and the point count. Requesters deal only in whole points.

---
 rtl/sram_pkg.sv | 23 ++
 rtl/sram_grant.sv | 50 +++++
 rtl/sram_point_arbiter.sv | 166 ++++++++++++++++
 tb/tb_sram_point_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM point store.
package sram_pkg;

  localparam int unsigned WORDS_PER_POINT = 3;
  localparam int unsigned ADDR_W          = 20;
  localparam int unsigned DQ_W            = 16;
  localparam int unsigned COUNT_W         = 21;

  typedef struct packed {
    logic [DQ_W-1:0] w2;
    logic [DQ_W-1:0] w1;
    logic [DQ_W-1:0] w0;
  } point_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_TURN,
    S_READ,
    S_DONE
  } state_e;

endpackage

// File: rtl/sram_grant.sv
// Read-priority arbiter with a starvation bound that forces a pending write through.
module sram_grant
  import sram_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_wr_valid,
  input  logic i_rd_valid,
  input  logic i_idle,
  input  logic i_full,
  input  logic i_clear_pending,
  output logic o_grant_wr,
  output logic o_grant_rd
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 2);

  logic [SW-1:0] starve_q, starve_d;
  logic          can_grant, wr_ok, starved;

  always_comb begin
    can_grant  = i_idle && !i_clear_pending;
    wr_ok      = i_wr_valid && !i_full;
    starved    = (starve_q == SW'(STARVE_LIMIT));
    o_grant_wr = can_grant && wr_ok && (starved || !i_rd_valid);
    o_grant_rd = can_grant && i_rd_valid && !o_grant_wr;
    starve_d   = starve_q;
    if (o_grant_wr) begin
      starve_d = '0;
    end else if (o_grant_rd) begin
      if (!i_wr_valid) begin
        starve_d = '0;
      end else if (!starved) begin
        // Saturates so a write blocked by full still wins once space frees up.
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/sram_point_arbiter.sv
// Single-port SRAM controller sharing 48-bit points (3 words each) between a writer and a reader.
module sram_point_arbiter
  import sram_pkg::*;
#(
  parameter int unsigned MAX_POINTS   = 349525,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_wr_valid,
  input  logic [47:0]        i_wr_point,
  output logic               o_wr_ready,
  input  logic               i_rd_valid,
  input  logic [18:0]        i_rd_index,
  output logic               o_rd_ready,
  output logic               o_rd_valid,
  output logic [47:0]        o_rd_point,
  output logic               o_rd_oob,
  output logic [COUNT_W-1:0] o_point_count,
  output logic               o_full,
  output logic [ADDR_W-1:0]  o_SRAM_ADDR,
  inout  wire  [DQ_W-1:0]    io_SRAM_DQ,
  output logic               o_SRAM_WE_N,
  output logic               o_SRAM_OE_N,
  output logic               o_SRAM_CE_N,
  output logic               o_SRAM_LB_N,
  output logic               o_SRAM_UB_N
);

  state_e              state_q, state_d;
  logic [1:0]          k_q, k_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  point_t              wr_point_q, wr_point_d;
  point_t              rd_data_q, rd_data_d;
  logic                rd_oob_q, rd_oob_d;
  logic                clear_pend_q, clear_pend_d;
  logic                clear_req, grant_wr, grant_rd;
  logic [ADDR_W-1:0]   idx_ext;
  logic [DQ_W-1:0]     wdata;

  assign clear_req = i_clear || clear_pend_q;
  assign o_full    = (count_q == COUNT_W'(MAX_POINTS));

  sram_grant #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_wr_valid      (i_wr_valid),
    .i_rd_valid      (i_rd_valid),
    .i_idle          (state_q == S_IDLE),
    .i_full          (o_full),
    .i_clear_pending (clear_req),
    .o_grant_wr      (grant_wr),
    .o_grant_rd      (grant_rd)
  );

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    count_d      = count_q;
    wr_point_d   = wr_point_q;
    rd_data_d    = rd_data_q;
    rd_oob_d     = rd_oob_q;
    clear_pend_d = clear_pend_q;
    idx_ext      = ADDR_W'(i_rd_index);
    // A clear seen mid-access is held until the bus returns to idle.
    if (i_clear && state_q != S_IDLE) clear_pend_d = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (clear_req) begin
          count_d      = '0;
          wr_addr_d    = '0;
          clear_pend_d = 1'b0;
        end else if (grant_wr) begin
          state_d    = S_WRITE;
          k_d        = '0;
          wr_point_d = i_wr_point;
        end else if (grant_rd) begin
          state_d   = S_READ;
          k_d       = '0;
          rd_addr_d = (idx_ext << 1) + idx_ext;
          rd_oob_d  = ({2'b00, i_rd_index} >= count_q);
        end
      end
      S_WRITE: begin
        k_d = k_q + 2'd1;
        if (k_q == 2'd2) begin
          k_d       = '0;
          count_d   = count_q + COUNT_W'(1);
          wr_addr_d = wr_addr_q + ADDR_W'(WORDS_PER_POINT);
          state_d   = S_TURN;
        end
      end
      S_TURN: state_d = S_IDLE;
      S_READ: begin
        k_d = k_q + 2'd1;
        unique case (k_q)
          2'd0:    rd_data_d.w0 = rd_oob_q ? '0 : io_SRAM_DQ;
          2'd1:    rd_data_d.w1 = rd_oob_q ? '0 : io_SRAM_DQ;
          default: rd_data_d.w2 = rd_oob_q ? '0 : io_SRAM_DQ;
        endcase
        if (k_q == 2'd2) begin
          k_d     = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      count_q      <= '0;
      wr_point_q   <= '0;
      rd_data_q    <= '0;
      rd_oob_q     <= 1'b0;
      clear_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      count_q      <= count_d;
      wr_point_q   <= wr_point_d;
      rd_data_q    <= rd_data_d;
      rd_oob_q     <= rd_oob_d;
      clear_pend_q <= clear_pend_d;
    end
  end

  always_comb begin
    o_SRAM_ADDR = '0;
    if (state_q == S_WRITE) o_SRAM_ADDR = wr_addr_q + ADDR_W'(k_q);
    if (state_q == S_READ)  o_SRAM_ADDR = rd_addr_q + ADDR_W'(k_q);
    unique case (k_q)
      2'd0:    wdata = wr_point_q.w0;
      2'd1:    wdata = wr_point_q.w1;
      default: wdata = wr_point_q.w2;
    endcase
  end

  assign io_SRAM_DQ    = (state_q == S_WRITE) ? wdata : 'z;
  assign o_SRAM_WE_N   = (state_q != S_WRITE);
  assign o_SRAM_OE_N   = (state_q != S_READ);
  assign o_SRAM_CE_N   = 1'b0;
  assign o_SRAM_LB_N   = 1'b0;
  assign o_SRAM_UB_N   = 1'b0;
  assign o_wr_ready    = grant_wr;
  assign o_rd_ready    = grant_rd;
  assign o_rd_valid    = (state_q == S_DONE);
  assign o_rd_point    = rd_data_q;
  assign o_rd_oob      = o_rd_valid && rd_oob_q;
  assign o_point_count = count_q;

endmodule

// File: tb/tb_sram_point_arbiter.sv
// Scoreboard bench: stimulus pushes expected bus ops and read results; a monitor pops and compares.
module tb_sram_point_arbiter;

  localparam int unsigned MAXP  = 4;
  localparam int unsigned LIMIT = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_clear = 1'b0;
  logic        i_wr_valid = 1'b0;
  logic [47:0] i_wr_point = '0;
  logic        i_rd_valid = 1'b0;
  logic [18:0] i_rd_index = '0;
  logic        o_wr_ready, o_rd_ready, o_rd_valid, o_rd_oob, o_full;
  logic [47:0] o_rd_point;
  logic [20:0] o_point_count;
  logic [19:0] o_SRAM_ADDR;
  wire  [15:0] io_SRAM_DQ;
  logic        we_n, oe_n, ce_n, lb_n, ub_n;

  sram_point_arbiter #(
    .MAX_POINTS   (MAXP),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_clear       (i_clear),
    .i_wr_valid    (i_wr_valid),
    .i_wr_point    (i_wr_point),
    .o_wr_ready    (o_wr_ready),
    .i_rd_valid    (i_rd_valid),
    .i_rd_index    (i_rd_index),
    .o_rd_ready    (o_rd_ready),
    .o_rd_valid    (o_rd_valid),
    .o_rd_point    (o_rd_point),
    .o_rd_oob      (o_rd_oob),
    .o_point_count (o_point_count),
    .o_full        (o_full),
    .o_SRAM_ADDR   (o_SRAM_ADDR),
    .io_SRAM_DQ    (io_SRAM_DQ),
    .o_SRAM_WE_N   (we_n),
    .o_SRAM_OE_N   (oe_n),
    .o_SRAM_CE_N   (ce_n),
    .o_SRAM_LB_N   (lb_n),
    .o_SRAM_UB_N   (ub_n)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural SRAM: unwritten words return an address-derived pattern.
  logic [15:0] mem [int];
  function automatic logic [15:0] mem_read(input logic [19:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return a[15:0] ^ 16'h5A5A;
  endfunction
  assign io_SRAM_DQ = (!oe_n && we_n) ? mem_read(o_SRAM_ADDR) : 16'hzzzz;
  always @(negedge i_clk) if (i_rst_n && !we_n) mem[int'(o_SRAM_ADDR)] = io_SRAM_DQ;

  typedef struct { bit is_wr; int addr; logic [15:0] data; } bus_op_t;
  typedef struct { logic [47:0] pt; bit oob; int cyc; } rd_exp_t;

  bus_op_t     bus_q[$];
  rd_exp_t     rd_q[$];
  byte         grant_log[$];
  logic [47:0] store [MAXP];
  int          model_cnt = 0;
  int          consec = 0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          wr_hs, rd_hs;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge i_clk) cyc++;

  always @(negedge i_clk) begin
    bus_op_t op;
    rd_exp_t e;
    int      a;
    if (!i_rst_n) begin
      wr_hs = 1'b0;
      rd_hs = 1'b0;
    end else begin
      if (!we_n && !oe_n) chk("we_oe_overlap", 1, 0);
      else if (!we_n || !oe_n) begin
        if (bus_q.size() == 0) chk("bus_unexpected", o_SRAM_ADDR, 0);
        else begin
          op = bus_q.pop_front();
          chk("bus_kind_we", !we_n, op.is_wr);
          chk("bus_addr", o_SRAM_ADDR, op.addr[19:0]);
          if (op.is_wr) chk("bus_wdata", io_SRAM_DQ, op.data);
        end
      end
      if (o_rd_valid) begin
        if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          e = rd_q.pop_front();
          chk("rd_point", o_rd_point, e.pt);
          chk("rd_oob", o_rd_oob, e.oob);
          chk("rd_latency", cyc, e.cyc);
        end
      end
      wr_hs = i_wr_valid && o_wr_ready;
      rd_hs = i_rd_valid && o_rd_ready;
      if (o_wr_ready && o_rd_ready) chk("both_ready", 1, 0);
      if (i_clear && (o_wr_ready || o_rd_ready)) chk("ready_on_clear", 1, 0);
      if (wr_hs || rd_hs) begin
        chk("count_at_grant", o_point_count, model_cnt);
        chk("full_at_grant", o_full, model_cnt == MAXP);
      end
      if (wr_hs) begin
        chk("wr_while_full", model_cnt < MAXP, 1);
        chk("wr_grant_rule", i_rd_valid && consec < LIMIT, 0);
        if (model_cnt < MAXP) begin
          for (int k = 0; k < 3; k++) begin
            op.is_wr = 1'b1;
            op.addr  = 3 * model_cnt + k;
            op.data  = i_wr_point[16*k +: 16];
            bus_q.push_back(op);
          end
          store[model_cnt] = i_wr_point;
          model_cnt++;
        end
        consec = 0;
        grant_log.push_back(8'h57);
      end
      if (rd_hs) begin
        chk("rd_grant_rule", i_wr_valid && model_cnt < MAXP && consec >= LIMIT, 0);
        e.oob = (int'(i_rd_index) >= model_cnt);
        e.pt  = e.oob ? 48'h0 : store[i_rd_index];
        e.cyc = cyc + 4;
        rd_q.push_back(e);
        for (int k = 0; k < 3; k++) begin
          a        = (3 * int'(i_rd_index) + k) & 32'hFFFFF;
          op.is_wr = 1'b0;
          op.addr  = a;
          op.data  = '0;
          bus_q.push_back(op);
        end
        consec = i_wr_valid ? ((consec < LIMIT) ? consec + 1 : LIMIT) : 0;
        grant_log.push_back(8'h52);
      end
      if (i_clear) model_cnt = 0;
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_write(input logic [47:0] pt);
    bit done = 1'b0;
    i_wr_valid = 1'b1;
    i_wr_point = pt;
    for (int n = 0; n < 200 && !done; n++) begin
      step();
      if (wr_hs) done = 1'b1;
    end
    if (!done) chk("wr_timeout", 0, 1);
    i_wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [18:0] idx);
    bit done = 1'b0;
    i_rd_valid = 1'b1;
    i_rd_index = idx;
    for (int n = 0; n < 200 && !done; n++) begin
      step();
      if (rd_hs) done = 1'b1;
    end
    if (!done) chk("rd_timeout", 0, 1);
    i_rd_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [63:0] r64;
    bit          found;
    // Reset values
    idle_cycles(3);
    @(negedge i_clk);
    chk("rst_we_n", we_n, 1);
    chk("rst_oe_n", oe_n, 1);
    chk("rst_addr", o_SRAM_ADDR, 0);
    chk("rst_count", o_point_count, 0);
    chk("rst_rd_valid", o_rd_valid, 0);
    chk("rst_rd_point", o_rd_point, 0);
    chk("rst_rd_oob", o_rd_oob, 0);
    chk("rst_ready", {o_wr_ready, o_rd_ready}, 0);
    chk("rst_tie", {ce_n, lb_n, ub_n}, 0);
    #2 i_rst_n = 1'b1;
    step();

    // Single write, then read it back; then an out-of-range read
    do_write(48'h3333_2222_1111);
    idle_cycles(6);
    chk("count_after_write", o_point_count, 1);
    do_read(19'd0);
    idle_cycles(6);
    do_write(48'hCAFE_BEEF_0042);
    idle_cycles(6);
    do_read(19'd5);
    idle_cycles(6);

    // Both requesters held: reads get LIMIT grants, then one write
    grant_log.delete();
    i_rd_index = 19'd1;
    i_rd_valid = 1'b1;
    i_wr_valid = 1'b1;
    r64 = {$urandom(), $urandom()};
    i_wr_point = r64[47:0];
    for (int n = 0; n < 200 && grant_log.size() < 10; n++) begin
      step();
      if (wr_hs) begin
        r64 = {$urandom(), $urandom()};
        i_wr_point = r64[47:0];
      end
    end
    i_rd_valid = 1'b0;
    i_wr_valid = 1'b0;
    chk("starve_grants", grant_log.size(), 10);
    for (int i = 0; i < 10 && i < grant_log.size(); i++)
      chk("starve_seq", grant_log[i], (i % 5 == 4) ? 8'h57 : 8'h52);
    idle_cycles(6);

    // Full: write held off until a clear empties the store
    chk("full_flag", o_full, 1);
    chk("full_count", o_point_count, MAXP);
    i_wr_valid = 1'b1;
    i_wr_point = 48'h0ABC_0DEF_0123;
    for (int n = 0; n < 8; n++) begin
      @(negedge i_clk);
      chk("full_no_ready", o_wr_ready, 0);
    end
    step();
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      if (wr_hs) found = 1'b1;
      else step();
    end
    chk("held_write_granted", found, 1);
    i_wr_valid = 1'b0;
    idle_cycles(6);
    chk("count_after_clear", o_point_count, 1);
    chk("full_after_clear", o_full, 0);

    // Reset in the middle of a write (word k=1 at address 4)
    i_wr_valid = 1'b1;
    i_wr_point = 48'h7777_6666_5555;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge i_clk);
      if (!we_n && o_SRAM_ADDR == 20'd4) found = 1'b1;
    end
    chk("mid_write_seen", found, 1);
    #2;
    i_rst_n    = 1'b0;
    i_wr_valid = 1'b0;
    #1;
    chk("async_rst_we_n", we_n, 1);
    chk("async_rst_oe_n", oe_n, 1);
    chk("async_rst_addr", o_SRAM_ADDR, 0);
    bus_q.delete();
    rd_q.delete();
    model_cnt = 0;
    consec    = 0;
    step();
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("count_after_rst", o_point_count, 0);
    step();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step();
      i_clear = 1'b0;
      if (i_wr_valid && wr_hs) i_wr_valid = 1'b0;
      if (i_rd_valid && rd_hs) i_rd_valid = 1'b0;
      if (!i_wr_valid && $urandom_range(0, 2) == 0) begin
        r64 = {$urandom(), $urandom()};
        i_wr_valid = 1'b1;
        i_wr_point = r64[47:0];
      end
      if (!i_rd_valid && $urandom_range(0, 2) == 0) begin
        i_rd_valid = 1'b1;
        if ($urandom_range(0, 9) == 0) i_rd_index = 19'($urandom());
        else i_rd_index = 19'($urandom_range(0, MAXP + 1));
      end
      if ($urandom_range(0, 60) == 0) i_clear = 1'b1;
    end
    i_clear    = 1'b0;
    i_wr_valid = 1'b0;
    i_rd_valid = 1'b0;
    idle_cycles(20);
    chk("bus_drain", bus_q.size(), 0);
    chk("rd_drain", rd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
